// File: rtl/reaction_match_controller.sv
// ---------------------------------------------------------------------------
// reaction_match_controller
//
// Round/match sequencer for a two-player reaction game. Each round runs
// blink -> dark wait (fixed part plus a random extra) -> live timer. The
// first press during the live timer wins the round. A press during the dark
// wait is a false start and gives the point to the other player. Points are
// kept as 5-bit thermometer scores, and the first player to reach WIN_TARGET
// points ends the match.
//
// Ports
//   clk           system clock (CLOCK_50 domain), rising edge only
//   reset         synchronous, active-high; returns everything to IDLE
//   tick_ms       one-clk pulse per millisecond, advances the phase counter
//   start         one-clk pulse: new match from IDLE/MATCH_END, else restart
//                 the current round
//   p1_press      one-clk conditioned button pulse, player 1
//   p2_press      one-clk conditioned button pulse, player 2
//   rnd_value     random extra dark-wait time in ms (14 bits)
//   rnd_ready     rnd_value is valid
//   hex_sel       display select: 000 blink, 001 dark, 010 live timer,
//                 011 winner time, 100 point P1, 101 point P2, 110 tie/void
//   timer_run     enable for the external live display counter
//   timer_clear   one-clk clear of the external live display counter
//   winner_time   reaction time captured at the end of the live phase (ms)
//   score1/score2 thermometer scores, LSB first
//   match_over    high while the match-end screen is shown
//   match_winner  01 P1, 10 P2, 00 none
// ---------------------------------------------------------------------------
module reaction_match_controller #(
  parameter int BLINK_MS     = 5000,
  parameter int BASE_WAIT_MS = 2000,
  parameter int TIMEOUT_MS   = 9999,
  parameter int RESULT_MS    = 3000,
  parameter int WIN_TARGET   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_ms,
  input  logic        start,
  input  logic        p1_press,
  input  logic        p2_press,
  input  logic [13:0] rnd_value,
  input  logic        rnd_ready,
  output logic [2:0]  hex_sel,
  output logic        timer_run,
  output logic        timer_clear,
  output logic [19:0] winner_time,
  output logic [4:0]  score1,
  output logic [4:0]  score2,
  output logic        match_over,
  output logic [1:0]  match_winner
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BLINK,
    S_WAIT,
    S_GO,
    S_RESULT,
    S_MATCH_END
  } state_t;

  localparam logic [2:0] HEX_BLINK = 3'b000;
  localparam logic [2:0] HEX_DARK  = 3'b001;
  localparam logic [2:0] HEX_LIVE  = 3'b010;
  localparam logic [2:0] HEX_TIME  = 3'b011;
  localparam logic [2:0] HEX_P1    = 3'b100;
  localparam logic [2:0] HEX_P2    = 3'b101;
  localparam logic [2:0] HEX_VOID  = 3'b110;

  localparam logic [19:0] BLINK_LIM   = 20'(BLINK_MS);
  localparam logic [19:0] TIMEOUT_LIM = 20'(TIMEOUT_MS);
  localparam logic [19:0] RESULT_LIM  = 20'(RESULT_MS);
  localparam logic [14:0] BASE_WAIT   = 15'(BASE_WAIT_MS);

  // A thermometer score holds WIN_TARGET points exactly when this bit is set.
  localparam int WIN_IDX = WIN_TARGET - 1;

  state_t      state, state_nxt;
  logic [19:0] ph_ms;
  logic [14:0] wait_tgt, wait_tgt_nxt;
  logic        prio_p2, prio_nxt;
  logic        enter;

  logic [2:0]  hex_nxt;
  logic        run_nxt;
  logic        clear_nxt;
  logic [19:0] win_time_nxt;
  logic [4:0]  score1_nxt, score2_nxt;
  logic        over_nxt;
  logic [1:0]  mwin_nxt;

  // Shifting a one in from the bottom keeps the score a thermometer code and
  // saturates at 5'b11111 without any extra compare.
  function automatic logic [4:0] add_point(input logic [4:0] s);
    return {s[3:0], 1'b1};
  endfunction

  // Next-state and next-output logic. Every output is produced here as a
  // "next" value and registered below, so the visible outputs always
  // describe the state being entered on the coming edge. start is checked
  // before anything else so that it beats a press arriving in the same clk.
  always_comb begin
    state_nxt    = state;
    wait_tgt_nxt = wait_tgt;
    prio_nxt     = prio_p2;
    hex_nxt      = hex_sel;
    run_nxt      = 1'b0;
    clear_nxt    = 1'b0;
    win_time_nxt = winner_time;
    score1_nxt   = score1;
    score2_nxt   = score2;
    over_nxt     = 1'b0;
    mwin_nxt     = 2'b00;
    enter        = 1'b0;

    if (start) begin
      state_nxt = S_BLINK;
      clear_nxt = 1'b1;
      enter     = 1'b1;
      if (state == S_IDLE || state == S_MATCH_END) begin
        score1_nxt = 5'b00000;
        score2_nxt = 5'b00000;
      end
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_BLINK: begin
          if (ph_ms >= BLINK_LIM && rnd_ready) begin
            wait_tgt_nxt = BASE_WAIT + {1'b0, rnd_value};
            state_nxt    = S_WAIT;
          end
        end

        S_WAIT: begin
          if (p1_press && p2_press) begin
            state_nxt = S_RESULT;
            hex_nxt   = HEX_VOID;
          end else if (p1_press) begin
            state_nxt  = S_RESULT;
            hex_nxt    = HEX_P2;
            score2_nxt = add_point(score2);
          end else if (p2_press) begin
            state_nxt  = S_RESULT;
            hex_nxt    = HEX_P1;
            score1_nxt = add_point(score1);
          end else if (ph_ms >= {5'b00000, wait_tgt}) begin
            state_nxt = S_GO;
            clear_nxt = 1'b1;
          end
        end

        S_GO: begin
          if (p1_press || p2_press) begin
            state_nxt    = S_RESULT;
            hex_nxt      = HEX_TIME;
            win_time_nxt = ph_ms;
            if (p1_press && p2_press) begin
              if (prio_p2) begin
                score2_nxt = add_point(score2);
              end else begin
                score1_nxt = add_point(score1);
              end
              prio_nxt = ~prio_p2;
            end else if (p1_press) begin
              score1_nxt = add_point(score1);
            end else begin
              score2_nxt = add_point(score2);
            end
          end else if (ph_ms >= TIMEOUT_LIM) begin
            state_nxt    = S_RESULT;
            hex_nxt      = HEX_VOID;
            win_time_nxt = TIMEOUT_LIM;
          end
        end

        S_RESULT: begin
          if (ph_ms >= RESULT_LIM) begin
            if (score1[WIN_IDX] || score2[WIN_IDX]) begin
              state_nxt = S_MATCH_END;
            end else begin
              state_nxt = S_BLINK;
              clear_nxt = 1'b1;
            end
          end
        end

        S_MATCH_END: begin
        end

        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end

    if (state_nxt != state) begin
      enter = 1'b1;
    end

    // Display select and status outputs follow the state being entered.
    // RESULT keeps whatever code was chosen on the transition into it.
    case (state_nxt)
      S_IDLE:   hex_nxt = HEX_DARK;
      S_BLINK:  hex_nxt = HEX_BLINK;
      S_WAIT:   hex_nxt = HEX_DARK;
      S_GO: begin
        hex_nxt = HEX_LIVE;
        run_nxt = 1'b1;
      end
      S_RESULT: begin
      end
      S_MATCH_END: begin
        over_nxt = 1'b1;
        if (score1_nxt[WIN_IDX]) begin
          mwin_nxt = 2'b01;
          hex_nxt  = HEX_P1;
        end else begin
          mwin_nxt = 2'b10;
          hex_nxt  = HEX_P2;
        end
      end
      default: hex_nxt = HEX_DARK;
    endcase
  end

  // State, phase counter and output registers. The phase counter restarts
  // on every state entry, including a restart of BLINK from BLINK, and
  // saturates rather than wrapping while parked in IDLE or MATCH_END.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      ph_ms        <= '0;
      wait_tgt     <= '0;
      prio_p2      <= 1'b0;
      hex_sel      <= HEX_DARK;
      timer_run    <= 1'b0;
      timer_clear  <= 1'b0;
      winner_time  <= '0;
      score1       <= '0;
      score2       <= '0;
      match_over   <= 1'b0;
      match_winner <= 2'b00;
    end else begin
      state        <= state_nxt;
      wait_tgt     <= wait_tgt_nxt;
      prio_p2      <= prio_nxt;
      hex_sel      <= hex_nxt;
      timer_run    <= run_nxt;
      timer_clear  <= clear_nxt;
      winner_time  <= win_time_nxt;
      score1       <= score1_nxt;
      score2       <= score2_nxt;
      match_over   <= over_nxt;
      match_winner <= mwin_nxt;
      if (enter) begin
        ph_ms <= '0;
      end else if (tick_ms && ph_ms != '1) begin
        ph_ms <= ph_ms + 20'd1;
      end
    end
  end

endmodule

// File: tb/tb_reaction_match_controller.sv
// ---------------------------------------------------------------------------
// tb_reaction_match_controller
//
// Self-checking bench for reaction_match_controller. Short blink, wait and
// result times keep the run small. The live-phase timeout stays at its
// default of 9999 ms. One tick_ms pulse is issued per clk while a phase is
// being timed. The expected scores, reaction times, press priority and
// match winner come from a point-count model of the game rules.
// ---------------------------------------------------------------------------
module tb_reaction_match_controller;

  localparam int T_BLINK   = 20;
  localparam int T_BASE    = 30;
  localparam int T_TIMEOUT = 9999;
  localparam int T_RESULT  = 15;
  localparam int T_WIN     = 5;

  localparam logic [19:0] H_BLINK = 20'd0;
  localparam logic [19:0] H_DARK  = 20'd1;
  localparam logic [19:0] H_LIVE  = 20'd2;
  localparam logic [19:0] H_TIME  = 20'd3;
  localparam logic [19:0] H_P1    = 20'd4;
  localparam logic [19:0] H_P2    = 20'd5;
  localparam logic [19:0] H_VOID  = 20'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_ms;
  logic        start;
  logic        p1_press;
  logic        p2_press;
  logic [13:0] rnd_value;
  logic        rnd_ready;
  logic [2:0]  hex_sel;
  logic        timer_run;
  logic        timer_clear;
  logic [19:0] winner_time;
  logic [4:0]  score1;
  logic [4:0]  score2;
  logic        match_over;
  logic [1:0]  match_winner;

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: points per player, who wins a tie next, last reaction time.
  int          pts1;
  int          pts2;
  logic        prio_p2;
  logic [19:0] exp_wt;
  int          cur_rv;

  always #5 clk = ~clk;

  reaction_match_controller #(
    .BLINK_MS    (T_BLINK),
    .BASE_WAIT_MS(T_BASE),
    .TIMEOUT_MS  (T_TIMEOUT),
    .RESULT_MS   (T_RESULT),
    .WIN_TARGET  (T_WIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_ms     (tick_ms),
    .start       (start),
    .p1_press    (p1_press),
    .p2_press    (p2_press),
    .rnd_value   (rnd_value),
    .rnd_ready   (rnd_ready),
    .hex_sel     (hex_sel),
    .timer_run   (timer_run),
    .timer_clear (timer_clear),
    .winner_time (winner_time),
    .score1      (score1),
    .score2      (score2),
    .match_over  (match_over),
    .match_winner(match_winner)
  );

  // Thermometer code for n points, capped at five lit bits.
  function automatic logic [19:0] thermo(input int n);
    int k;
    k = (n > 5) ? 5 : n;
    return 20'((1 << k) - 1);
  endfunction

  // Drive one clk worth of inputs, then return just after the edge.
  task automatic applyStimulus(input logic t, input logic s, input logic a, input logic b);
    @(negedge clk);
    tick_ms  = t;
    start    = s;
    p1_press = a;
    p2_press = b;
    @(posedge clk);
    #1;
    tick_ms  = 1'b0;
    start    = 1'b0;
    p1_press = 1'b0;
    p2_press = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [19:0] observed, input logic [19:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkScores(input string tag);
    checkOutput({tag, " score1"}, 20'(score1), thermo(pts1));
    checkOutput({tag, " score2"}, 20'(score2), thermo(pts2));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " hex"},    20'(hex_sel),      H_DARK);
    checkOutput({tag, " run"},    20'(timer_run),    20'd0);
    checkOutput({tag, " clear"},  20'(timer_clear),  20'd0);
    checkOutput({tag, " time"},   winner_time,       20'd0);
    checkOutput({tag, " score1"}, 20'(score1),       20'd0);
    checkOutput({tag, " score2"}, 20'(score2),       20'd0);
    checkOutput({tag, " over"},   20'(match_over),   20'd0);
    checkOutput({tag, " winner"}, 20'(match_winner), 20'd0);
  endtask

  // Start pulse: always lands in the blink phase with a counter clear.
  task automatic startRound(input string tag, input logic new_match);
    if (new_match) begin
      pts1 = 0;
      pts2 = 0;
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput({tag, " start hex"},   20'(hex_sel),      H_BLINK);
    checkOutput({tag, " start clear"}, 20'(timer_clear),  20'd1);
    checkOutput({tag, " start over"},  20'(match_over),   20'd0);
    checkOutput({tag, " start win"},   20'(match_winner), 20'd0);
    checkScores({tag, " start"});
  endtask

  // Blink phase from its first clk; the last tick carries ignored presses.
  task automatic blinkToWait(input string tag, input int rv);
    cur_rv    = rv;
    rnd_value = 14'(rv);
    rnd_ready = 1'b1;
    ticks(T_BLINK - 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput({tag, " blink hold"},  20'(hex_sel),     H_BLINK);
    checkOutput({tag, " blink clear"}, 20'(timer_clear), 20'd0);
    checkScores({tag, " blink press"});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " wait entry"}, 20'(hex_sel), H_DARK);
  endtask

  task automatic waitToGo(input string tag);
    ticks(T_BASE + cur_rv);
    checkOutput({tag, " wait hold"}, 20'(hex_sel), H_DARK);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, " go hex"},   20'(hex_sel),     H_LIVE);
    checkOutput({tag, " go run"},   20'(timer_run),   20'd1);
    checkOutput({tag, " go clear"}, 20'(timer_clear), 20'd1);
  endtask

  task automatic checkResult(input string tag, input logic [19:0] exp_hex);
    checkOutput({tag, " res hex"},  20'(hex_sel),   exp_hex);
    checkOutput({tag, " res time"}, winner_time,    exp_wt);
    checkOutput({tag, " res run"},  20'(timer_run), 20'd0);
    checkScores({tag, " res"});
  endtask

  // Result hold, with an ignored press on the last tick, then either the
  // next round's blink phase or the match-end screen.
  task automatic resultPhase(input string tag, input logic [19:0] exp_hex);
    ticks(T_RESULT - 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput({tag, " res hold"}, 20'(hex_sel), exp_hex);
    checkScores({tag, " res press"});
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (pts1 >= T_WIN || pts2 >= T_WIN) begin
      checkOutput({tag, " end over"},   20'(match_over),   20'd1);
      checkOutput({tag, " end winner"}, 20'(match_winner), (pts1 >= T_WIN) ? 20'd1 : 20'd2);
      checkOutput({tag, " end hex"},    20'(hex_sel),      (pts1 >= T_WIN) ? H_P1 : H_P2);
    end else begin
      checkOutput({tag, " next hex"},   20'(hex_sel),     H_BLINK);
      checkOutput({tag, " next clear"}, 20'(timer_clear), 20'd1);
      checkOutput({tag, " next over"},  20'(match_over),  20'd0);
    end
  endtask

  // Both players press in the same clk of the live phase.
  task automatic tieRound(input string tag);
    int d;
    blinkToWait(tag, int'($urandom_range(0, 40)));
    waitToGo(tag);
    d = int'($urandom_range(0, 200));
    ticks(d);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    exp_wt = 20'(d);
    if (prio_p2) pts2++;
    else         pts1++;
    prio_p2 = ~prio_p2;
    checkResult(tag, H_TIME);
  endtask

  initial begin
    int d;

    reset     = 1'b1;
    tick_ms   = 1'b0;
    start     = 1'b0;
    p1_press  = 1'b0;
    p2_press  = 1'b0;
    rnd_value = '0;
    rnd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkReset("reset");
    reset   = 1'b0;
    pts1    = 0;
    pts2    = 0;
    prio_p2 = 1'b0;
    exp_wt  = '0;

    $display("[TB] normal round");
    startRound("A", 1'b1);
    blinkToWait("A", 1000);
    waitToGo("A");
    ticks(250);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    exp_wt = 20'd250;
    pts1++;
    checkResult("A", H_TIME);
    resultPhase("A", H_TIME);

    $display("[TB] false starts");
    blinkToWait("B", 200);
    ticks(100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    pts1++;
    checkResult("B", H_P1);
    resultPhase("B", H_P1);

    blinkToWait("C", int'($urandom_range(0, 40)));
    ticks(5);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    pts2++;
    checkResult("C", H_P2);
    resultPhase("C", H_P2);

    blinkToWait("D", int'($urandom_range(0, 40)));
    ticks(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkResult("D", H_VOID);
    resultPhase("D", H_VOID);

    $display("[TB] ties in the live phase");
    tieRound("E");
    resultPhase("E", H_TIME);
    tieRound("F");
    resultPhase("F", H_TIME);

    $display("[TB] timeout");
    blinkToWait("G", int'($urandom_range(0, 40)));
    waitToGo("G");
    ticks(T_TIMEOUT);
    checkOutput("G timeout hold hex", 20'(hex_sel),   H_LIVE);
    checkOutput("G timeout hold run", 20'(timer_run), 20'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    exp_wt = 20'(T_TIMEOUT);
    checkResult("G", H_VOID);
    resultPhase("G", H_VOID);

    $display("[TB] restart beats press");
    blinkToWait("H", int'($urandom_range(0, 40)));
    waitToGo("H");
    ticks(7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("H abort hex",   20'(hex_sel),     H_BLINK);
    checkOutput("H abort clear", 20'(timer_clear), 20'd1);
    checkOutput("H abort time",  winner_time,      exp_wt);
    checkScores("H abort");

    $display("[TB] random rounds to match end");
    while (pts1 < T_WIN) begin
      blinkToWait("R", int'($urandom_range(0, 40)));
      if ($urandom_range(0, 1) == 1) begin
        d = int'($urandom_range(0, T_BASE + cur_rv - 1));
        ticks(d);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        pts1++;
        checkResult("R false", H_P1);
        resultPhase("R false", H_P1);
      end else begin
        waitToGo("R");
        d = int'($urandom_range(0, 300));
        ticks(d);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        exp_wt = 20'(d);
        pts1++;
        checkResult("R go", H_TIME);
        resultPhase("R go", H_TIME);
      end
    end
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("M hold over",   20'(match_over),   20'd1);
    checkOutput("M hold winner", 20'(match_winner), 20'd1);
    checkOutput("M hold score1", 20'(score1),       20'h1f);
    startRound("M", 1'b1);

    $display("[TB] priority kept across matches");
    tieRound("P");
    resultPhase("P", H_TIME);

    $display("[TB] rnd_ready low at blink end");
    rnd_ready = 1'b0;
    cur_rv    = int'($urandom_range(0, 40));
    rnd_value = 14'(cur_rv);
    ticks(T_BLINK);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("Q blink stall", 20'(hex_sel), H_BLINK);
    rnd_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("Q wait entry", 20'(hex_sel), H_DARK);
    waitToGo("Q");
    ticks(11);

    $display("[TB] reset in the live phase");
    @(negedge clk);
    reset    = 1'b1;
    tick_ms  = 1'b1;
    p1_press = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tick_ms  = 1'b0;
    p1_press = 1'b0;
    start    = 1'b0;
    checkReset("mid reset");
    pts1    = 0;
    pts2    = 0;
    prio_p2 = 1'b0;
    exp_wt  = '0;

    startRound("S", 1'b1);
    tieRound("S");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
